// File: rtl/omega_pingpong_buffer.sv
// Multi-bank ping-pong omega/syndrome store between the key-equation solver and Chien/Forney.
// Define OMEGA_PINGPONG_OUTREG_EN to add a second read register (read latency 2 instead of 1).
module omega_pingpong_buffer #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int NUM_BANKS = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [DATA_W-1:0]                data,
    input  logic                             wren,
    input  logic [ADDR_W-1:0]                wraddress,
    input  logic                             wr_done,
    output logic                             wr_ready,
    input  logic [ADDR_W-1:0]                rdaddress,
    input  logic                             rden,
    input  logic                             rd_done,
    output logic                             rd_valid,
    output logic [DATA_W-1:0]                q,
    output logic                             q_valid,
    output logic [$clog2(NUM_BANKS+1)-1:0]   full_count
);

    localparam int PTR_W = $clog2(NUM_BANKS);
    localparam int CNT_W = $clog2(NUM_BANKS + 1);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_t;

    bank_state_t        bank_state      [NUM_BANKS];
    bank_state_t        bank_state_next [NUM_BANKS];
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0]   count_next;
    logic               wr_accept;
    logic               rd_accept;
    logic               rd_fire;

    logic [DATA_W-1:0]  mem [NUM_BANKS][DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_BANKS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_ready  = (bank_state[wr_ptr] == FILLING);
    assign rd_valid  = (full_count != '0);
    assign wr_accept = wr_done && wr_ready;
    assign rd_accept = rd_done && rd_valid;
    assign rd_fire   = rden && rd_valid;

    // Bank ownership next-state. Decisions look at the pre-edge bank states, so a bank
    // released in the same cycle as wr_done is only claimed by the writer one cycle later.
    always_comb begin
        bank_state_next = bank_state;
        wr_ptr_next     = wr_ptr;
        rd_ptr_next     = rd_ptr;
        count_next      = full_count + CNT_W'(wr_accept) - CNT_W'(rd_accept);

        if (rd_accept) begin
            bank_state_next[rd_ptr] = EMPTY;
            rd_ptr_next             = ptr_inc(rd_ptr);
        end

        if (wr_accept) begin
            bank_state_next[wr_ptr] = FULL;
            wr_ptr_next             = ptr_inc(wr_ptr);
            if (bank_state[wr_ptr_next] == EMPTY)
                bank_state_next[wr_ptr_next] = FILLING;
        end else if (bank_state[wr_ptr] == EMPTY) begin
            bank_state_next[wr_ptr] = FILLING;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BANKS; i++)
                bank_state[i] <= EMPTY;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            full_count <= '0;
        end else begin
            bank_state <= bank_state_next;
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            full_count <= count_next;
        end
    end

    // NOTE: the RAM has no reset; clearing it would defeat block-RAM inference and
    // every location is rewritten before the reader may consume it.
    always_ff @(posedge clock) begin
        if (wren && wr_ready)
            mem[wr_ptr][wraddress] <= data;
    end

`ifdef OMEGA_PINGPONG_OUTREG_EN
    logic [DATA_W-1:0] q_ram;
    logic              q_ram_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_ram       <= '0;
            q_ram_valid <= 1'b0;
            q           <= '0;
            q_valid     <= 1'b0;
        end else begin
            if (rd_fire)
                q_ram <= mem[rd_ptr][rdaddress];
            q_ram_valid <= rd_fire;
            q           <= q_ram;
            q_valid     <= q_ram_valid;
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            if (rd_fire)
                q <= mem[rd_ptr][rdaddress];
            q_valid <= rd_fire;
        end
    end
`endif

endmodule

// File: tb/tb_omega_pingpong_buffer.sv
// Self-checking bench for omega_pingpong_buffer: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of bank ownership and contents.
module tb_omega_pingpong_buffer;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int NB    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(NB + 1);
`ifdef OMEGA_PINGPONG_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic [DW-1:0] data;
    logic          wren;
    logic [AW-1:0] wraddress;
    logic          wr_done;
    logic          wr_ready;
    logic [AW-1:0] rdaddress;
    logic          rden;
    logic          rd_done;
    logic          rd_valid;
    logic [DW-1:0] q;
    logic          q_valid;
    logic [CW-1:0] full_count;

    int checks   = 0;
    int failures = 0;

    omega_pingpong_buffer #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
        .clock(clock), .reset_n(reset_n), .data(data), .wren(wren), .wraddress(wraddress),
        .wr_done(wr_done), .wr_ready(wr_ready), .rdaddress(rdaddress), .rden(rden),
        .rd_done(rd_done), .rd_valid(rd_valid), .q(q), .q_valid(q_valid),
        .full_count(full_count)
    );

    always #5 clock = ~clock;

    // Model: FIFO of full banks in handover order, writer ownership flag, output pipeline.
    logic [DW-1:0] m_mem [NB][DEPTH];
    bit            m_written [NB][DEPTH];
    int            full_q[$];
    bit            m_owns;
    int            m_wp;
    logic [DW-1:0] s_q [LAT];
    bit            s_v [LAT];
    bit            s_k [LAT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_full(input int b);
        foreach (full_q[i]) if (full_q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        full_q.delete();
        m_owns = 1'b0;
        m_wp   = 0;
        for (int i = 0; i < LAT; i++) begin
            s_q[i] = '0; s_v[i] = 1'b0; s_k[i] = 1'b1;
        end
    endtask

    task automatic model_step(input bit i_wren, input bit i_wdone, input bit i_rden,
                              input bit i_rdone, input logic [AW-1:0] wa,
                              input logic [AW-1:0] ra, input logic [DW-1:0] d);
        bit owns_pre, have_full, wacc, racc, rv, rk, next_free, cur_free;
        logic [DW-1:0] rq;
        int nxt;
        owns_pre  = m_owns;
        have_full = (full_q.size() > 0);
        wacc      = i_wdone && owns_pre;
        racc      = i_rdone && have_full;
        nxt       = (m_wp + 1) % NB;
        next_free = !in_full(nxt);
        cur_free  = !in_full(m_wp);
        if (i_rden && have_full) begin
            rq = m_mem[full_q[0]][ra]; rk = m_written[full_q[0]][ra]; rv = 1'b1;
        end else begin
            rq = s_q[0]; rk = s_k[0]; rv = 1'b0;
        end
        for (int i = LAT - 1; i > 0; i--) begin
            s_q[i] = s_q[i-1]; s_v[i] = s_v[i-1]; s_k[i] = s_k[i-1];
        end
        s_q[0] = rq; s_v[0] = rv; s_k[0] = rk;
        if (i_wren && owns_pre) begin
            m_mem[m_wp][wa] = d; m_written[m_wp][wa] = 1'b1;
        end
        if (wacc) begin
            full_q.push_back(m_wp);
            m_wp   = nxt;
            m_owns = next_free;
        end else if (!owns_pre) begin
            m_owns = cur_free;
        end
        if (racc) void'(full_q.pop_front());
    endtask

    // Compare process: advance the model on each edge, then check all outputs 1 ns later.
    always @(posedge clock) begin
        if (reset_n === 1'b1) begin
            model_step(wren, wr_done, rden, rd_done, wraddress, rdaddress, data);
            #1;
            if (reset_n === 1'b1) begin
                check("wr_ready", 32'(wr_ready), 32'(m_owns));
                check("rd_valid", 32'(rd_valid), 32'(full_q.size() > 0));
                check("full_count", 32'(full_count), 32'(full_q.size()));
                check("q_valid", 32'(q_valid), 32'(s_v[LAT-1]));
                if (s_k[LAT-1]) check("q", 32'(q), 32'(s_q[LAT-1]));
            end
        end
    end

    task automatic idle();
        wren = 0; wr_done = 0; rden = 0; rd_done = 0;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic fill(input int n, input logic [DW-1:0] pat, input bit add);
        for (int a = 0; a < n; a++) begin
            wren = 1; wraddress = AW'(a);
            data = add ? DW'(a) + pat : DW'(a) ^ pat;
            step();
        end
        idle();
    endtask

    task automatic read_lit(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rden = 1; rdaddress = a;
        step();
        rden = 0;
        for (int i = 1; i < LAT; i++) step();
        check({name, "_q"}, 32'(q), 32'(exp));
        check({name, "_qv"}, 32'(q_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset_n = 0; data = '0; wraddress = '0; rdaddress = '0;
        idle();
        #3;
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_full_count", 32'(full_count), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_q_valid", 32'(q_valid), 32'd0);
        step(); step();
        reset_n = 1;
        step();
        check("post_rst_wr_ready", 32'(wr_ready), 32'd1);

        // Fill bank 0 and hand it over.
        fill(DEPTH, 8'hA5, 1'b0);
        wr_done = 1; step(); idle();
        check("fill_rd_valid", 32'(rd_valid), 32'd1);
        check("fill_full_count", 32'(full_count), 32'd1);

        // Read back the whole bank; the compare process checks every word.
        for (int a = 0; a < DEPTH; a++) begin
            rden = 1; rdaddress = AW'(a); step();
        end
        idle();
        for (int i = 0; i < LAT; i++) step();
        read_lit("rd3", 8'd3, 8'hA6);

        // Fill bank 1 too: writer stalls, writes are dropped.
        fill(DEPTH, 8'h5A, 1'b0);
        wr_done = 1; step(); idle();
        check("stall_wr_ready", 32'(wr_ready), 32'd0);
        check("stall_full_count", 32'(full_count), 32'd2);
        wren = 1; wraddress = 8'd3; data = 8'hFF; step(); idle();
        rd_done = 1; step(); idle();
        check("release_wr_ready_same", 32'(wr_ready), 32'd0);
        step();
        check("release_wr_ready_next", 32'(wr_ready), 32'd1);
        read_lit("stall_addr3", 8'd3, 8'h59);

        // Simultaneous handover: bank 0 refilled, bank 1 released in the same cycle.
        fill(16, 8'h30, 1'b1);
        wr_done = 1; rd_done = 1; step(); idle();
        check("sim_full_count", 32'(full_count), 32'd1);
        check("sim_rd_valid", 32'(rd_valid), 32'd1);
        check("sim_wr_ready", 32'(wr_ready), 32'd0);
        step();
        check("sim_wr_ready_next", 32'(wr_ready), 32'd1);
        read_lit("sim_addr5", 8'd5, 8'h35);

        // Illegal strobes with nothing full.
        rd_done = 1; step(); idle();
        check("drain_full_count", 32'(full_count), 32'd0);
        rden = 1; rd_done = 1; rdaddress = 8'd7; step(); idle();
        for (int i = 1; i < LAT; i++) step();
        check("illegal_q_valid", 32'(q_valid), 32'd0);
        check("illegal_q", 32'(q), 32'h35);
        check("illegal_full_count", 32'(full_count), 32'd0);

        // Asynchronous reset in the middle of a burst.
        fill(8, 8'h11, 1'b1);
        wr_done = 1; step(); idle();
        check("midrst_pre_count", 32'(full_count), 32'd1);
        wren = 1; rden = 1; rdaddress = 8'd2;
        for (int i = 0; i < 3; i++) begin
            wraddress = AW'(i); data = DW'(i); step();
        end
        #2;
        reset_n = 0;
        model_reset();
        #1;
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_q_valid", 32'(q_valid), 32'd0);
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_full_count", 32'(full_count), 32'd0);
        idle();
        step();
        reset_n = 1;
        step();
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            wren      = ($urandom_range(0, 1) == 1);
            wraddress = AW'($urandom_range(0, 15));
            data      = DW'($urandom);
            wr_done   = ($urandom_range(0, 15) == 0);
            rden      = ($urandom_range(0, 1) == 1);
            rdaddress = AW'($urandom_range(0, 15));
            rd_done   = ($urandom_range(0, 17) == 0);
            step();
        end
        idle();
        for (int i = 0; i < LAT + 1; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/omega_pingpong_buffer.md
Name: omega_pingpong_buffer

Overview:
- Parametrised multi-bank syndrome/omega storage for the Reed-Solomon decoder, placed between the key-equation solver (writer) and the Chien/Forney stage (reader).
- The writer fills one bank while the reader drains another. Banks are handed over with a done/ready handshake, so codeword processing overlaps without stalls.
- Generalises the single 8x256 omega RAM to configurable width, depth and bank count, with bank ownership tracking and registered read data.

Parameters:
- DATA_W, 8, symbol width in bits.
- ADDR_W, 8, address width per bank; depth per bank = 2**ADDR_W.
- NUM_BANKS, 2, number of banks; legal range 2..8.

Ports:
- clock  input  1  single rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- data  input  DATA_W  write symbol.
- wren  input  1  write strobe into the current write bank.
- wraddress  input  ADDR_W  write address within the write bank.
- wr_done  input  1  one-cycle pulse: the current write bank is complete; hand it to the reader.
- wr_ready  output  1  a write bank is owned by the writer, so writes are accepted.
- rdaddress  input  ADDR_W  read address within the current read bank.
- rden  input  1  read strobe.
- rd_done  input  1  one-cycle pulse: the reader has finished the current read bank; release it.
- rd_valid  output  1  a full bank is available to the reader.
- q  output  DATA_W  read data.
- q_valid  output  1  q holds data for a rden issued at the configured latency.
- full_count  output  $clog2(NUM_BANKS+1)  number of banks in the full state.

Behaviour:
- Each bank is in one of three states: EMPTY, FILLING or FULL.
- At most one bank is FILLING, at the index held in wr_ptr. Reads come from the FULL bank at rd_ptr.
- Both pointers wrap modulo NUM_BANKS. Banks are handed over in strict round-robin order.
- Reset (asynchronous, reset_n=0):
  - all banks EMPTY, except bank 0, which enters FILLING on the first clock after release;
  - wr_ptr=0, rd_ptr=0, full_count=0, rd_valid=0, q_valid=0, q=0;
  - wr_ready=0 during reset and 1 from the first clock after release;
  - RAM contents are not cleared.
- Write path:
  - When wren=1 and wr_ready=1, data is written to bank wr_ptr at wraddress on the clock edge.
  - When wr_ready=0, wren is ignored and nothing is written.
- wr_done while wr_ready=1:
  - bank wr_ptr becomes FULL and full_count increments;
  - wr_ptr advances;
  - if the next bank is EMPTY it becomes FILLING and wr_ready stays 1, otherwise wr_ready drops to 0;
  - a wren in the same cycle as wr_done still writes to the old bank.
- wr_done while wr_ready=0 is ignored.
- While wr_ready=0, the first cycle after a bank is released, that bank (which must equal the wr_ptr bank) becomes FILLING. wr_ready rises one cycle after the rd_done edge.
- Read path:
  - rd_valid=1 when full_count>0.
  - rden=1 with rd_valid=1 reads bank rd_ptr at rdaddress.
  - q and q_valid update on the next edge (latency 1).
  - rden with rd_valid=0 gives q_valid=0 on the next edge, and q holds its previous value.
- rd_done while rd_valid=1:
  - bank rd_ptr becomes EMPTY and full_count decrements;
  - rd_ptr advances;
  - a rden in the same cycle reads the old bank.
- rd_done while rd_valid=0 is ignored.
- wr_done and rd_done in the same cycle:
  - full_count is unchanged and both pointers advance;
  - if wr_ready had been 0, the release makes a bank available, and wr_ready rises the following cycle.
- Same-bank read/write cannot occur by construction, because FILLING and FULL are exclusive. No read-during-write forwarding is required.
- full_count never exceeds NUM_BANKS-1 while a bank is FILLING, and never exceeds NUM_BANKS.

Optional Feature:
- Macro: OMEGA_PINGPONG_OUTREG_EN.
- Defined: a second output register is added after the RAM read. Read latency is 2; q_valid is delayed by the same 2 cycles and still follows rden/rd_valid. Both pipeline stages reset to 0.
- Undefined: read latency is 1, as described above.

Test Plan:
- Reset then fill:
  - Stimulus: release reset; write addresses 0..255 with data=addr^8'hA5; pulse wr_done.
  - Required: wr_ready=1 throughout, rd_valid=1 one cycle after wr_done, full_count=1, wr_ptr=1.
- Read back:
  - Stimulus: with bank 0 FULL, rden for addresses 0..255.
  - Required: q=addr^8'hA5 one cycle after each rden, q_valid=1; with OMEGA_PINGPONG_OUTREG_EN, two cycles after.
- Full stall (NUM_BANKS=2):
  - Stimulus: fill bank 0, then bank 1, each followed by wr_done.
  - Required: wr_ready=0, full_count=2; a wren of 8'hFF at address 3 is ignored, and a later read of bank 1 address 3 returns its original value.
  - Follow-up: pulse rd_done; wr_ready returns to 1 one cycle after that edge.
- Simultaneous handover:
  - Stimulus: with full_count=1 and writer filling, pulse wr_done and rd_done in the same cycle.
  - Required: full_count stays 1, both pointers advance, rd_valid stays 1, and subsequent reads return the newly written bank's data.
- Illegal strobes:
  - Stimulus: rden and rd_done while rd_valid=0.
  - Required: q_valid=0, q unchanged, full_count unchanged.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 asynchronously mid-burst with full_count=1.
  - Required: rd_valid=0, q_valid=0, q=0 and full_count=0 immediately without a clock edge; wr_ready=1 one clock after release.
